// File: rtl/count_checker.sv
// Passive checker for a free-running up-counter: locks onto the observed
// enable/count stream, then flags illegal transitions and reports wraps.
module count_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             error,
  output logic [7:0]       err_count,
  output logic             wrap,
  output logic [WIDTH-1:0] expected
);

  localparam int unsigned RUN_W = 4;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   prev_count, prev_count_n;
  logic               prev_en, prev_en_n;
  logic [RUN_W-1:0]   run, run_n;
  logic               locked_n, error_n, wrap_n;
  logic [ERR_W-1:0]   err_count_n;

  logic               consistent;
  logic               wrap_hit;
  logic [RUN_W-1:0]   run_inc;

  // Value the counter must present this cycle, derived from the last sample
  always_comb begin
    expected = '0;
    if (state != IDLE) expected = prev_count + WIDTH'(prev_en);
  end

  assign consistent = (count == expected);
  assign wrap_hit   = (prev_count == '1) && prev_en && (count == '0);
  assign run_inc    = run + RUN_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    run_n        = run;
    locked_n     = locked;
    error_n      = 1'b0;
    wrap_n       = 1'b0;
    err_count_n  = err_count;
    prev_count_n = count;
    prev_en_n    = enable;

    case (state)
      IDLE: begin
        state_n  = ACQ;
        run_n    = '0;
        locked_n = 1'b0;
      end
      ACQ: begin
        wrap_n = wrap_hit;
        if (consistent) begin
          run_n = run_inc;
          if (run_inc == RUN_W'(LOCK_LEN)) begin
            state_n  = TRACK;
            locked_n = 1'b1;
          end
        end else begin
          run_n = '0;
        end
      end
      TRACK: begin
        wrap_n = wrap_hit;
        if (!consistent) begin
          error_n  = 1'b1;
          locked_n = 1'b0;
          run_n    = '0;
          state_n  = ACQ;
          if (err_count != '1) err_count_n = err_count + ERR_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        run_n    = '0;
        locked_n = 1'b0;
      end
    endcase
  end

  // Reset overrides every transition, including a simultaneous mismatch
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev_count <= '0;
      prev_en    <= 1'b0;
      run        <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
      wrap       <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      prev_count <= prev_count_n;
      prev_en    <= prev_en_n;
      run        <= run_n;
      locked     <= locked_n;
      error      <= error_n;
      wrap       <= wrap_n;
      err_count  <= err_count_n;
    end
  end

endmodule

// File: doc/count_checker.md
# count_checker

Passive in-line checker that watches a free-running up-counter's `enable` input and `count` output and verifies every transition. It sits beside the counter on the same `clk`/`reset` and consumes the counter's interface from the observing end. It acquires lock after a run of consistent transitions. While locked it flags every illegal transition, saturating-counts errors and reports wrap-around events. It is used in benches and as an on-chip health monitor; it never drives the counter.

## Interface

- `WIDTH`, default 4: width of the observed count.
- `LOCK_LEN`, default 4: consecutive consistent transitions required to assert `locked`; legal range 1..15.
- `clk`, input, 1: rising-edge clock shared with the counter.
- `reset`, input, 1: synchronous, active-high; the same reset the counter receives.
- `enable`, input, 1: the counter's enable, as driven to the counter.
- `count`, input, WIDTH: the counter's output.
- `locked`, output, 1: checker is tracking; errors are reported only while high.
- `error`, output, 1: one-cycle pulse on an illegal transition observed while locked.
- `err_count`, output, 8: number of errors since reset; saturates at 255.
- `wrap`, output, 1: one-cycle pulse on a legal all-ones→0 transition.
- `expected`, output, WIDTH: value `count` must show in the current cycle.

## Operation

- Counter model, per edge n, with C[n] and E[n] being the values sampled at edge n:
  - C[n+1] = 0 if `reset`.
  - Otherwise C[n+1] = (C[n] + E[n]) mod 2^WIDTH.
- Internal registers:
  - `prev_count`, `prev_en`: last sampled values, updated every non-reset edge.
  - `run`: 4-bit consistent-transition counter.
  - `state`: one of IDLE, ACQ, TRACK.
- `expected` = (`prev_count` + `prev_en`) mod 2^WIDTH; it is 0 in IDLE. A sample is consistent when `count` == `expected`.
- **IDLE** (entered on `reset`):
  - On the first edge with `reset`=0, capture `prev_count`/`prev_en`, set `run`=0 and go to ACQ.
  - No compare is made on this edge.
- **ACQ**:
  - Consistent sample: `run`++. When `run` reaches LOCK_LEN, go to TRACK and set `locked`=1.
  - Inconsistent sample: `run`=0 and stay in ACQ. No `error` pulse and no `err_count` change.
- **TRACK**:
  - Consistent sample: stay in TRACK.
  - Inconsistent sample: pulse `error`, increment `err_count` (saturating), clear `locked`, set `run`=0 and go to ACQ.
- `prev_*` always take the observed values, including after a mismatch. The checker therefore resynchronises to whatever the counter actually shows.
- `wrap` pulses in ACQ or TRACK when `prev_count` is all ones, `prev_en`=1 and `count`=0. It is never asserted together with `error`.
- `enable`=0 with `count` changing is an error in the same way as a wrong increment.
- `err_count` saturation: at 255, further errors still pulse `error`, but the count holds at 255.

## Timing

- All outputs are registered except `expected`, which is combinational from registers.
- Reset values (visible the cycle after the reset edge): `locked`=0, `error`=0, `wrap`=0, `err_count`=0, `expected`=0, state IDLE, `run`=0.
- Latency: `error` and `wrap` are high for exactly the one cycle after the edge that sampled the offending or wrapping `count`.
- `locked` lock timing:
  - Rises in the cycle after the LOCK_LEN-th consistent compare.
  - With back-to-back consistent samples, that is LOCK_LEN+1 edges after reset deasserts.
- `locked` falls in the same cycle that `error` rises.
- Reset mid-operation: `reset`=1 at any edge overrides all transitions, including a simultaneous mismatch. The next cycle shows reset values, with no error pulse and `err_count` cleared.
- `reset` held for several cycles: the checker stays in IDLE and compares nothing.
- Simultaneous mismatch and saturation: the `error` pulse still occurs and `err_count` stays at 255.

## Test plan

Bench settings: WIDTH=4, LOCK_LEN=4, 10 ns clock.

- **Lock on hold:** one cycle of reset, then `enable`=0 with `count` held at 0 → `locked` rises in the cycle after the 5th post-reset edge; `error`=0 and `err_count`=0 throughout.
- **Count and wrap:** after lock, `enable`=1 for 20 cycles so `count` runs 0..15,0..3 → exactly one `wrap` pulse, in the cycle after `count` shows 0. `expected` matches `count` every cycle; `err_count`=0.
- **Skip error:** while locked and counting, force `count` to jump 5→7 → one `error` pulse and `err_count`=1. `locked` drops, then re-asserts after 4 further correct increments (8..11) with no second error.
- **Hold violation:** locked, `enable`=0, `count` changes 3→4 → one `error` pulse and `err_count`=1. In a separate run, inject a bad sample while in ACQ → no `error` and `err_count` unchanged.
- **Saturation:** run 260 cycles of mismatch-then-relock → `err_count` reaches 255 and holds there. `error` still pulses on every mismatch.
- **Reset mid-TRACK:** while locked with `err_count`=3, assert `reset` on the same edge as an injected mismatch → no `error` pulse. The next cycle shows `locked`=0 and `err_count`=0, and the checker relocks normally afterwards.
